// File: rtl/ysyx_24100029_load_scoreboard_if.sv
// Pipeline-side signal bundle for the load scoreboard: IDU request/ready,
// EXU load dispatch, LSU writeback, flush and the status outputs.
interface ysyx_24100029_load_scoreboard_if #(
  parameter int CNT_W = 32
);
  logic             idu_valid;
  logic [4:0]       idu_rs1;
  logic [4:0]       idu_rs2;
  logic             idu_rs1_used;
  logic             idu_rs2_used;
  logic [4:0]       idu_rd;
  logic             idu_is_load;
  logic             idu_ready;

  logic             exu_valid;
  logic             exu_is_load;
  logic [4:0]       exu_rd;
  logic             exu_fire;

  logic             lsu_resp_valid;
  logic [4:0]       lsu_resp_rd;

  logic             flush;

  logic [31:0]      pending;
  logic [3:0]       outstanding;
  logic [CNT_W-1:0] stall_cycles;

  // Pipeline side: drives the stage information and observes ready/status.
  modport master (
    output idu_valid, idu_rs1, idu_rs2, idu_rs1_used, idu_rs2_used, idu_rd, idu_is_load,
    output exu_valid, exu_is_load, exu_rd, exu_fire,
    output lsu_resp_valid, lsu_resp_rd, flush,
    input  idu_ready, pending, outstanding, stall_cycles
  );

  modport slave (
    input  idu_valid, idu_rs1, idu_rs2, idu_rs1_used, idu_rs2_used, idu_rd, idu_is_load,
    input  exu_valid, exu_is_load, exu_rd, exu_fire,
    input  lsu_resp_valid, lsu_resp_rd, flush,
    output idu_ready, pending, outstanding, stall_cycles
  );
endinterface

// File: rtl/ysyx_24100029_load_scoreboard.sv
// Load scoreboard: tracks rd of loads between EXU dispatch and LSU writeback,
// holds IDU on unresolvable dependencies and sequences the post-flush drain.
module ysyx_24100029_load_scoreboard #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_24100029_load_scoreboard_if.slave sb
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN} state_t;

  state_t           state_reg;
  logic [31:0]      pending_reg;
  logic [31:0]      pending_next;
  logic [3:0]       outstanding_reg;
  logic [3:0]       outstanding_next;
  logic [CNT_W-1:0] stall_cycles_reg;

  logic       exu_load;
  logic       h1;
  logic       h2;
  logic       waw;
  logic       full;
  logic       hold;
  logic       stall_req;
  logic       ready;
  logic       set_en;
  logic       clr_en;
  logic       inc;
  logic [4:0] in_flight;

  // Hazard detection uses the registered bitmap only: a load returning this
  // cycle still blocks its consumer for one conservative bubble.
  assign exu_load = sb.exu_valid & sb.exu_is_load;

  assign h1 = sb.idu_rs1_used & (sb.idu_rs1 != 5'd0) &
              ((exu_load & (sb.exu_rd == sb.idu_rs1)) | pending_reg[sb.idu_rs1]);
  assign h2 = sb.idu_rs2_used & (sb.idu_rs2 != 5'd0) &
              ((exu_load & (sb.exu_rd == sb.idu_rs2)) | pending_reg[sb.idu_rs2]);

  assign waw = sb.idu_valid & sb.idu_is_load & (sb.idu_rd != 5'd0) & pending_reg[sb.idu_rd];

  assign in_flight = {1'b0, outstanding_reg} + {4'd0, exu_load};
  assign full      = sb.idu_is_load & (in_flight >= 5'(MAX_OUTSTANDING));

  assign hold      = h1 | h2 | waw | full;
  assign stall_req = sb.idu_valid & hold;
  assign ready     = (state_reg != DRAIN) & ~hold;

  // During DRAIN the EXU-side load is squashed, so it must not be tracked.
  assign set_en = sb.exu_fire & sb.exu_is_load & (state_reg != DRAIN);
  assign clr_en = sb.lsu_resp_valid & (outstanding_reg != 4'd0);
  assign inc    = set_en & (outstanding_reg != 4'hF);

  always_comb begin
    outstanding_next = outstanding_reg;
    if (inc && !clr_en) begin
      outstanding_next = outstanding_reg + 4'd1;
    end else if (!inc && clr_en) begin
      outstanding_next = outstanding_reg - 4'd1;
    end
  end

  // Per-register update: a set to the same rd as a clear wins.
  assign pending_next[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pending
      assign pending_next[gi] =
        (set_en && (sb.exu_rd == 5'(gi)))      ? 1'b1 :
        (clr_en && (sb.lsu_resp_rd == 5'(gi))) ? 1'b0 :
                                                 pending_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= RUN;
      pending_reg      <= 32'd0;
      outstanding_reg  <= 4'd0;
      stall_cycles_reg <= '0;
    end else begin
      pending_reg     <= pending_next;
      outstanding_reg <= outstanding_next;
      if (sb.idu_valid && !ready) begin
        stall_cycles_reg <= stall_cycles_reg + 1'b1;
      end
      // Flush overrides every other transition, including leaving DRAIN.
      case (state_reg)
        RUN: begin
          if (sb.flush)        state_reg <= DRAIN;
          else if (stall_req)  state_reg <= STALL;
        end
        STALL: begin
          if (sb.flush)        state_reg <= DRAIN;
          else if (!stall_req) state_reg <= RUN;
        end
        DRAIN: begin
          if (!sb.flush && (outstanding_reg == 4'd0) && !sb.lsu_resp_valid) begin
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  assign sb.idu_ready    = ready;
  assign sb.pending      = pending_reg;
  assign sb.outstanding  = outstanding_reg;
  assign sb.stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_ysyx_24100029_load_scoreboard.sv
// Directed bench for the load scoreboard: load-use, x0, FULL, same-cycle
// set/clear, WAW, flush drain, underflow and mid-operation reset.
module tb_ysyx_24100029_load_scoreboard;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  ysyx_24100029_load_scoreboard_if #(.CNT_W(32)) sb_if ();

  ysyx_24100029_load_scoreboard #(
    .MAX_OUTSTANDING(4),
    .CNT_W(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sb   (sb_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb_if.idu_valid      = 1'b0;
    sb_if.idu_rs1        = 5'd0;
    sb_if.idu_rs2        = 5'd0;
    sb_if.idu_rs1_used   = 1'b0;
    sb_if.idu_rs2_used   = 1'b0;
    sb_if.idu_rd         = 5'd0;
    sb_if.idu_is_load    = 1'b0;
    sb_if.exu_valid      = 1'b0;
    sb_if.exu_is_load    = 1'b0;
    sb_if.exu_rd         = 5'd0;
    sb_if.exu_fire       = 1'b0;
    sb_if.lsu_resp_valid = 1'b0;
    sb_if.lsu_resp_rd    = 5'd0;
    sb_if.flush          = 1'b0;
  endtask

  task automatic fire_load(input logic [4:0] rd);
    sb_if.exu_valid   = 1'b1;
    sb_if.exu_is_load = 1'b1;
    sb_if.exu_rd      = rd;
    sb_if.exu_fire    = 1'b1;
  endtask

  task automatic exu_off();
    sb_if.exu_valid   = 1'b0;
    sb_if.exu_is_load = 1'b0;
    sb_if.exu_rd      = 5'd0;
    sb_if.exu_fire    = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %h want 0", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d want 0", sb_if.outstanding); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", sb_if.stall_cycles); end
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", sb_if.idu_ready); end
    $display("test_reset done");
  endtask

  task automatic test_load_use();
    fire_load(5'd5);
    sb_if.idu_valid = 1'b1; sb_if.idu_rs1 = 5'd5; sb_if.idu_rs1_used = 1'b1; sb_if.idu_rd = 5'd6;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_exu: got %b want 0", sb_if.idu_ready); end
    tick();
    n_cmp++; if (sb_if.pending !== 32'h20) begin n_err++; $display("FAIL lu_pending_set: got %h want 00000020", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd1) begin n_err++; $display("FAIL lu_outstanding: got %0d want 1", sb_if.outstanding); end
    exu_off();
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd5;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL lu_ready_no_bypass: got %b want 0", sb_if.idu_ready); end
    tick();
    sb_if.lsu_resp_valid = 1'b0;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL lu_ready_after_resp: got %b want 1", sb_if.idu_ready); end
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL lu_pending_clr: got %h want 0", sb_if.pending); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd2) begin n_err++; $display("FAIL lu_stall_cycles: got %0d want 2", sb_if.stall_cycles); end
    tick();
    idle();
    tick();
    $display("test_load_use done");
  endtask

  task automatic test_x0();
    fire_load(5'd0);
    sb_if.idu_valid = 1'b1; sb_if.idu_rs1_used = 1'b1; sb_if.idu_rs2_used = 1'b1;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready_exu: got %b want 1", sb_if.idu_ready); end
    tick();
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL x0_pending: got %h want 0", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd1) begin n_err++; $display("FAIL x0_outstanding: got %0d want 1", sb_if.outstanding); end
    exu_off();
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd0;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL x0_ready_out: got %b want 1", sb_if.idu_ready); end
    tick();
    idle();
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL x0_outstanding_clr: got %0d want 0", sb_if.outstanding); end
    $display("test_x0 done");
  endtask

  task automatic test_same_cycle();
    fire_load(5'd7);
    tick();
    n_cmp++; if (sb_if.pending !== 32'h80) begin n_err++; $display("FAIL sc_pending_set: got %h want 00000080", sb_if.pending); end
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd7;
    tick();
    n_cmp++; if (sb_if.pending !== 32'h80) begin n_err++; $display("FAIL sc_pending_setwins: got %h want 00000080", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd1) begin n_err++; $display("FAIL sc_outstanding: got %0d want 1", sb_if.outstanding); end
    exu_off();
    tick();
    idle();
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL sc_pending_clr: got %h want 0", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL sc_outstanding_clr: got %0d want 0", sb_if.outstanding); end
    $display("test_same_cycle done");
  endtask

  task automatic test_full();
    for (int i = 1; i <= 4; i++) begin
      fire_load(5'(i));
      tick();
    end
    exu_off();
    n_cmp++; if (sb_if.outstanding !== 4'd4) begin n_err++; $display("FAIL full_outstanding: got %0d want 4", sb_if.outstanding); end
    n_cmp++; if (sb_if.pending !== 32'h1E) begin n_err++; $display("FAIL full_pending: got %h want 0000001e", sb_if.pending); end
    sb_if.idu_valid = 1'b1; sb_if.idu_is_load = 1'b1; sb_if.idu_rd = 5'd10;
    sb_if.idu_rs1 = 5'd11; sb_if.idu_rs1_used = 1'b1;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", sb_if.idu_ready); end
    tick();
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd1;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL full_ready_resp: got %b want 0", sb_if.idu_ready); end
    tick();
    sb_if.lsu_resp_valid = 1'b0;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL full_ready_after: got %b want 1", sb_if.idu_ready); end
    n_cmp++; if (sb_if.outstanding !== 4'd3) begin n_err++; $display("FAIL full_outstanding_dec: got %0d want 3", sb_if.outstanding); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd4) begin n_err++; $display("FAIL full_stall_cycles: got %0d want 4", sb_if.stall_cycles); end
    tick();
    idle();
    for (int i = 2; i <= 4; i++) begin
      sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'(i);
      tick();
    end
    idle();
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL full_drained: got %0d want 0", sb_if.outstanding); end
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL full_pending_clr: got %h want 0", sb_if.pending); end
    $display("test_full done");
  endtask

  task automatic test_waw();
    fire_load(5'd5);
    tick();
    exu_off();
    sb_if.idu_valid = 1'b1; sb_if.idu_is_load = 1'b1; sb_if.idu_rd = 5'd6;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL waw_other_rd: got %b want 1", sb_if.idu_ready); end
    sb_if.idu_rd = 5'd5;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL waw_same_rd: got %b want 0", sb_if.idu_ready); end
    tick();
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd5;
    tick();
    sb_if.lsu_resp_valid = 1'b0;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL waw_ready_after: got %b want 1", sb_if.idu_ready); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd6) begin n_err++; $display("FAIL waw_stall_cycles: got %0d want 6", sb_if.stall_cycles); end
    tick();
    idle();
    tick();
    $display("test_waw done");
  endtask

  task automatic test_flush();
    fire_load(5'd8);
    tick();
    fire_load(5'd9);
    tick();
    exu_off();
    n_cmp++; if (sb_if.outstanding !== 4'd2) begin n_err++; $display("FAIL fl_outstanding: got %0d want 2", sb_if.outstanding); end
    sb_if.idu_valid = 1'b1; sb_if.idu_rs1 = 5'd20; sb_if.idu_rs1_used = 1'b1;
    sb_if.flush = 1'b1;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_flush_cycle: got %b want 1", sb_if.idu_ready); end
    tick();
    sb_if.flush = 1'b0;
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd8;
    fire_load(5'd12);
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_drain1: got %b want 0", sb_if.idu_ready); end
    tick();
    exu_off();
    n_cmp++; if (sb_if.outstanding !== 4'd1) begin n_err++; $display("FAIL fl_outstanding_d1: got %0d want 1", sb_if.outstanding); end
    n_cmp++; if (sb_if.pending !== 32'h200) begin n_err++; $display("FAIL fl_pending_squash: got %h want 00000200", sb_if.pending); end
    sb_if.lsu_resp_rd = 5'd9;
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_drain2: got %b want 0", sb_if.idu_ready); end
    tick();
    sb_if.lsu_resp_valid = 1'b0;
    #1;
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL fl_outstanding_d2: got %0d want 0", sb_if.outstanding); end
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL fl_ready_drain3: got %b want 0", sb_if.idu_ready); end
    tick();
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready_run: got %b want 1", sb_if.idu_ready); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd9) begin n_err++; $display("FAIL fl_stall_cycles: got %0d want 9", sb_if.stall_cycles); end
    idle();
    tick();
    $display("test_flush done");
  endtask

  task automatic test_underflow();
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd3;
    tick();
    idle();
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL uf_outstanding: got %0d want 0", sb_if.outstanding); end
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL uf_pending: got %h want 0", sb_if.pending); end
    $display("test_underflow done");
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    fire_load(5'd9);
    tick();
    exu_off();
    n_cmp++; if (sb_if.outstanding !== 4'd1) begin n_err++; $display("FAIL rm_outstanding: got %0d want 1", sb_if.outstanding); end
    sb_if.exu_valid = 1'b1; sb_if.exu_is_load = 1'b1; sb_if.exu_rd = 5'd5;
    sb_if.idu_valid = 1'b1; sb_if.idu_rs1 = 5'd5; sb_if.idu_rs1_used = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (sb_if.stall_cycles !== 32'd3) begin n_err++; $display("FAIL rm_stall_before: got %0d want 3", sb_if.stall_cycles); end
    n_cmp++; if (sb_if.idu_ready !== 1'b0) begin n_err++; $display("FAIL rm_ready_before: got %b want 0", sb_if.idu_ready); end
    rst_n = 1'b0;
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd9;
    tick();
    n_cmp++; if (sb_if.pending !== 32'd0) begin n_err++; $display("FAIL rm_pending: got %h want 0", sb_if.pending); end
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL rm_outstanding_rst: got %0d want 0", sb_if.outstanding); end
    n_cmp++; if (sb_if.stall_cycles !== 32'd0) begin n_err++; $display("FAIL rm_stall_rst: got %0d want 0", sb_if.stall_cycles); end
    idle();
    #1;
    n_cmp++; if (sb_if.idu_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready_rst: got %b want 1", sb_if.idu_ready); end
    rst_n = 1'b1;
    sb_if.lsu_resp_valid = 1'b1; sb_if.lsu_resp_rd = 5'd9;
    tick();
    idle();
    n_cmp++; if (sb_if.outstanding !== 4'd0) begin n_err++; $display("FAIL rm_late_resp: got %0d want 0", sb_if.outstanding); end
    $display("test_reset_mid done");
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_load_use();
    test_x0();
    test_same_cycle();
    test_full();
    test_waw();
    test_flush();
    test_underflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
